// File: rtl/mod461_pkg.sv
// -----------------------------------------------------------------------------
// mod461_pkg
//   Shared constants and types for the mod-461 residue datapath.
//   MOD461_M       modulus
//   MOD461_INV400  multiplicative inverse of 400 modulo 461 (400*68 = 59*461 + 1)
//   MOD461_W       residue width (2^W > M)
//   mod461_state_t FSM encoding for the sequential scaler
// -----------------------------------------------------------------------------
package mod461_pkg;

  localparam int MOD461_M      = 461;
  localparam int MOD461_INV400 = 68;
  localparam int MOD461_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod461_state_t;

endpackage

// File: rtl/mod461_horner_step.sv
// -----------------------------------------------------------------------------
// mod461_horner_step
//   One combinational Horner step of a modular constant multiply:
//     acc_next = (2*acc + (b ? C : 0)) mod M
//   Requires acc < M and C < M, so every half-step needs at most one
//   conditional subtract and W+1 bits of headroom.
// Ports
//   acc       in   W  current accumulator, in [0, M-1]
//   b         in   1  current operand bit (MSB first)
//   acc_next  out  W  updated accumulator, in [0, M-1]
// -----------------------------------------------------------------------------
module mod461_horner_step
  import mod461_pkg::*;
#(
  parameter int W = MOD461_W,
  parameter int M = MOD461_M,
  parameter int C = MOD461_INV400
) (
  input  logic [W-1:0] acc,
  input  logic         b,
  output logic [W-1:0] acc_next
);

  localparam logic [W:0] M_X = (W+1)'(M);
  localparam logic [W:0] C_X = (W+1)'(C);

  logic [W:0] dbl;
  logic [W:0] dbl_red;
  logic [W:0] sum;

  always_comb begin
    dbl      = {acc, 1'b0};
    dbl_red  = (dbl >= M_X) ? (dbl - M_X) : dbl;
    sum      = dbl_red + (b ? C_X : '0);
    acc_next = W'((sum >= M_X) ? (sum - M_X) : sum);
  end

endmodule

// File: rtl/x_inv400_mod461_seq.sv
// -----------------------------------------------------------------------------
// x_inv400_mod461_seq
//   Sequential inverse scaler: out_res = (in_res * 400^-1) mod 461, i.e.
//   (in_res * 68) mod 461, evaluated bit-serially (Horner, MSB first).
//   Any W-bit operand is handled, including values in [M, 2^W-1].
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operand valid
//   in_ready   out  1  operand can be accepted (IDLE only)
//   in_res     in   W  operand residue
//   out_valid  out  1  result valid, held until out_ready
//   out_ready  in   1  downstream accepts result
//   out_res    out  W  (in_res*C) mod M
//   busy       out  1  RUN or DONE
//   range_err  out  1  present only with MOD461_RANGE_CHK_EN; operand was >= M,
//                      qualified by out_valid
// Optional feature macro: MOD461_RANGE_CHK_EN
// -----------------------------------------------------------------------------
module x_inv400_mod461_seq
  import mod461_pkg::*;
#(
  parameter int W = MOD461_W,
  parameter int M = MOD461_M,
  parameter int C = MOD461_INV400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         busy
`ifdef MOD461_RANGE_CHK_EN
  ,
  output logic         range_err
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  mod461_state_t  state_reg;
  logic [W-1:0]   acc_reg;
  logic [W-1:0]   shift_reg;
  logic [CW-1:0]  cnt_reg;
  // Set once the final Horner step has been taken; the following RUN cycle
  // moves acc into the output register so out_res comes straight from a flop.
  logic           last_reg;
  logic [W-1:0]   acc_next;
`ifdef MOD461_RANGE_CHK_EN
  logic           range_flag_reg;
`endif

  mod461_horner_step #(
    .W (W),
    .M (M),
    .C (C)
  ) u_step (
    .acc      (acc_reg),
    .b        (shift_reg[W-1]),
    .acc_next (acc_next)
  );

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      last_reg       <= 1'b0;
      out_res        <= '0;
      out_valid      <= 1'b0;
      in_ready       <= 1'b0;
`ifdef MOD461_RANGE_CHK_EN
      range_flag_reg <= 1'b0;
      range_err      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Registered ready: rises one edge after reset release.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shift_reg      <= in_res;
            acc_reg        <= '0;
            cnt_reg        <= CW'(W - 1);
            last_reg       <= 1'b0;
            in_ready       <= 1'b0;
            state_reg      <= RUN;
`ifdef MOD461_RANGE_CHK_EN
            range_flag_reg <= (in_res >= W'(M));
`endif
          end
        end
        RUN: begin
          if (last_reg) begin
            out_res   <= acc_reg;
            out_valid <= 1'b1;
            state_reg <= DONE;
`ifdef MOD461_RANGE_CHK_EN
            range_err <= range_flag_reg;
`endif
          end else begin
            acc_reg   <= acc_next;
            shift_reg <= shift_reg << 1;
            cnt_reg   <= cnt_reg - 1'b1;
            last_reg  <= (cnt_reg == '0);
          end
        end
        DONE: begin
          // out_res is left holding the last result after the handshake.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
`ifdef MOD461_RANGE_CHK_EN
            range_err <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
